// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates NumReq memory requesters onto one downstream
// request channel through a single registered output slot. It tracks how many
// accepted requests still await a response, stops accepting at MaxOutstanding,
// and routes responses back to their source.
// Build option: define MEM_REQ_ARBITER_FIXED_PRIO_EN for fixed-priority grant
// (lowest index wins). Otherwise the grant is round-robin.
module mem_req_arbiter #(
  parameter int NumReq         = 3,
  parameter int AddrWidth      = 64,
  parameter int TidWidth       = 4,
  parameter int MaxOutstanding = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*TidWidth-1:0]    req_tid_i,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [TidWidth-1:0]           mem_tid_o,
  output logic [$clog2(NumReq)-1:0]     mem_src_o,
  input  logic                          rsp_valid_i,
  input  logic [$clog2(NumReq)-1:0]     rsp_src_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [3:0]                    outstanding_o,
  output logic                          err_o
);

  localparam int         SrcW   = $clog2(NumReq);
  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

  // IDLE: output slot empty; SEND: slot full and presented downstream;
  // STALL: slot empty but the outstanding budget is exhausted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  err_q;
  logic                  err_d;

  // Output slot (one register stage between grant and downstream).
  logic [AddrWidth-1:0]  addr_p1;
  logic [TidWidth-1:0]   tid_p1;
  logic [SrcW-1:0]       src_p1;

  logic                  gnt_found;
  logic [SrcW-1:0]       gnt_idx;
  logic [AddrWidth-1:0]  sel_addr;
  logic [TidWidth-1:0]   sel_tid;
  logic                  slot_free;
  logic                  can_load;
  logic                  accept;
  logic                  rsp_dec;
  logic                  rsp_underflow;
  logic                  rsp_bad_src;

`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN

  // Fixed priority: the lowest-numbered valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!gnt_found && req_valid_i[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = SrcW'(i);
      end
    end
  end

`else

  // Index of the most recently accepted requester; the search starts just after it.
  logic [SrcW-1:0] ptr_q;

  // Round-robin: walk offsets 1..NumReq from the pointer and take the first valid.
  // The pointer itself is visited last, so a lone requester can win repeatedly.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NumReq; k++) begin
      for (int j = 0; j < NumReq; j++) begin
        if (!gnt_found && req_valid_i[j] &&
            ((32'(ptr_q) + 32'(k)) % 32'(NumReq)) == 32'(j)) begin
          gnt_found = 1'b1;
          gnt_idx   = SrcW'(j);
        end
      end
    end
  end

  // Pointer moves only when a request is actually taken; reset points at the
  // last requester so requester 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= SrcW'(NumReq - 1);
    end else if (accept) begin
      ptr_q <= gnt_idx;
    end
  end

`endif

  // Select the granted requester's address and ID from the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_tid  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_idx == SrcW'(i)) begin
        sel_addr = req_addr_i[i*AddrWidth +: AddrWidth];
        sel_tid  = req_tid_i[i*TidWidth +: TidWidth];
      end
    end
  end

  // The slot can take a new request when empty, or when it drains this cycle.
  // STALL never loads: it must first observe a response freeing a slot.
  assign slot_free = (cnt_q < MaxCnt);
  assign can_load  = (state_q == IDLE) || ((state_q == SEND) && mem_ready_i);
  assign accept    = rst_ni && gnt_found && slot_free && can_load;

  // Ready is the one-hot grant, only in a cycle where the accept really happens.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = accept && (gnt_idx == SrcW'(i));
    end
  end

  // Response classification: a legal response frees one slot; a response with
  // nothing outstanding or an out-of-range source is a protocol error.
  assign rsp_dec       = rsp_valid_i && (cnt_q != 4'd0);
  assign rsp_underflow = rsp_valid_i && (cnt_q == 4'd0);
  assign rsp_bad_src   = rsp_valid_i && (32'(rsp_src_i) >= 32'(NumReq));

  // Route the response to its requester; an out-of-range source matches no bit.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = rsp_valid_i && (32'(rsp_src_i) == 32'(i));
    end
  end

  // Outstanding count and sticky error next-state.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | rsp_underflow | rsp_bad_src;
    case ({accept, rsp_dec})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Next-state logic for the output slot FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (mem_ready_i) begin
          if (accept) begin
            state_d = SEND;
          end else if ((cnt_q == MaxCnt) && !rsp_dec) begin
            state_d = STALL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STALL: begin
        if (rsp_dec || (cnt_q != MaxCnt)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, outstanding count, sticky error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ---- stage p1: output slot, loaded on accept and held otherwise ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_p1 <= '0;
      tid_p1  <= '0;
      src_p1  <= '0;
    end else if (accept) begin
      addr_p1 <= sel_addr;
      tid_p1  <= sel_tid;
      src_p1  <= gnt_idx;
    end
  end

  assign mem_valid_o   = (state_q == SEND);
  assign mem_addr_o    = addr_p1;
  assign mem_tid_o     = tid_p1;
  assign mem_src_o     = src_p1;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter with default parameters.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_mem_req_arbiter;

  localparam int NumReq    = 3;
  localparam int AddrWidth = 64;
  localparam int TidWidth  = 4;
  localparam int SrcW      = 2;

  logic                        clk_i;
  logic                        rst_ni;
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*TidWidth-1:0]  req_tid_i;
  logic                        mem_valid_o;
  logic                        mem_ready_i;
  logic [AddrWidth-1:0]        mem_addr_o;
  logic [TidWidth-1:0]         mem_tid_o;
  logic [SrcW-1:0]             mem_src_o;
  logic                        rsp_valid_i;
  logic [SrcW-1:0]             rsp_src_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [3:0]                  outstanding_o;
  logic                        err_o;

  int checks;
  int errors;

  mem_req_arbiter #(
    .NumReq(NumReq), .AddrWidth(AddrWidth), .TidWidth(TidWidth), .MaxOutstanding(7)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_tid_i(req_tid_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_tid_o(mem_tid_o), .mem_src_o(mem_src_o),
    .rsp_valid_i(rsp_valid_i), .rsp_src_i(rsp_src_i), .rsp_valid_o(rsp_valid_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [AddrWidth-1:0] base_addr(input int i);
    return 64'hA000_0000_0000_0000 + 64'(i) * 64'h100;
  endfunction

  // Advance to the next falling edge (one rising edge has passed).
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic init_payload();
    for (int i = 0; i < NumReq; i++) begin
      req_addr_i[i*AddrWidth +: AddrWidth] = base_addr(i);
      req_tid_i[i*TidWidth +: TidWidth]    = 4'(i + 5);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 3'b111; mem_ready_i = 1'b1;
    rsp_valid_i = 1'b0; rsp_src_i = '0;
    init_payload();
    next_cycle(); #1;
    checks++;
    if (req_ready_o !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready_o); end
    next_cycle(); #1;
    checks++;
    if (mem_valid_o !== 1'b0 || outstanding_o !== 4'd0 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_state got vld=%b cnt=%0d err=%b exp 0/0/0", mem_valid_o, outstanding_o, err_o);
    end
    checks++;
    if (mem_addr_o !== 64'd0 || mem_tid_o !== 4'd0 || mem_src_o !== 2'd0) begin
      errors++; $display("FAIL reset_payload got %h/%h/%0d exp 0", mem_addr_o, mem_tid_o, mem_src_o);
    end
    req_valid_i = 3'b000;
    rst_ni = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_g[6];
`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      req_valid_i = 3'b111; mem_ready_i = 1'b1;
      rsp_valid_i = (i > 0);
      rsp_src_i   = (i > 0) ? SrcW'(exp_g[i-1]) : 2'd0;
      #1;
      checks++;
      if (req_ready_o !== 3'(1 << exp_g[i])) begin
        errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_ready_o, 3'(1 << exp_g[i]));
      end
      if (i > 0) begin
        checks++;
        if (mem_valid_o !== 1'b1 || mem_src_o !== SrcW'(exp_g[i-1]) || mem_addr_o !== base_addr(exp_g[i-1])
            || mem_tid_o !== 4'(exp_g[i-1] + 5)) begin
          errors++; $display("FAIL rr_payload[%0d] got v=%b src=%0d addr=%h tid=%h exp src=%0d",
                             i, mem_valid_o, mem_src_o, mem_addr_o, mem_tid_o, exp_g[i-1]);
        end
        checks++;
        if (rsp_valid_o !== 3'(1 << exp_g[i-1]) || outstanding_o !== 4'd1) begin
          errors++; $display("FAIL rr_rsp[%0d] got rsp=%b cnt=%0d exp rsp=%b cnt=1",
                             i, rsp_valid_o, outstanding_o, 3'(1 << exp_g[i-1]));
        end
      end
    end
    // Drain: last request leaves, its response returns, no new accept.
    next_cycle();
    req_valid_i = 3'b000; rsp_valid_i = 1'b1; rsp_src_i = SrcW'(exp_g[5]);
    #1;
    checks++;
    if (req_ready_o !== 3'b000 || mem_src_o !== SrcW'(exp_g[5])) begin
      errors++; $display("FAIL rr_drain got ready=%b src=%0d exp 000/%0d", req_ready_o, mem_src_o, exp_g[5]);
    end
    next_cycle();
    rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (mem_valid_o !== 1'b0 || outstanding_o !== 4'd0) begin
      errors++; $display("FAIL rr_idle got vld=%b cnt=%0d exp 0/0", mem_valid_o, outstanding_o);
    end
  endtask

  task automatic test_hold_stable();
    next_cycle();
    req_valid_i = 3'b010; mem_ready_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 3'b010) begin errors++; $display("FAIL hold_accept got %b exp 010", req_ready_o); end
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      req_addr_i[1*AddrWidth +: AddrWidth] = 64'hDEAD_0000_0000_0000 + 64'(c);
      req_tid_i[1*TidWidth +: TidWidth]    = 4'(c);
      #1;
      checks++;
      if (mem_valid_o !== 1'b1 || mem_addr_o !== base_addr(1) || mem_tid_o !== 4'd6 ||
          mem_src_o !== 2'd1 || req_ready_o !== 3'b000) begin
        errors++; $display("FAIL hold[%0d] got v=%b addr=%h tid=%h src=%0d rdy=%b exp 1/%h/6/1/000",
                           c, mem_valid_o, mem_addr_o, mem_tid_o, mem_src_o, req_ready_o, base_addr(1));
      end
    end
    next_cycle();
    mem_ready_i = 1'b1;
    req_addr_i[1*AddrWidth +: AddrWidth] = 64'h0000_0000_0000_BEEF;
    req_tid_i[1*TidWidth +: TidWidth]    = 4'hC;
    #1;
    checks++;
    if (req_ready_o !== 3'b010 || outstanding_o !== 4'd1) begin
      errors++; $display("FAIL hold_release got rdy=%b cnt=%0d exp 010/1", req_ready_o, outstanding_o);
    end
    next_cycle();
    req_valid_i = 3'b000;
    #1;
    checks++;
    if (mem_addr_o !== 64'h0000_0000_0000_BEEF || mem_tid_o !== 4'hC || outstanding_o !== 4'd2) begin
      errors++; $display("FAIL hold_second got addr=%h tid=%h cnt=%0d exp BEEF/C/2", mem_addr_o, mem_tid_o, outstanding_o);
    end
    init_payload();
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      rsp_valid_i = 1'b1; rsp_src_i = 2'd1;
    end
    next_cycle();
    rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 4'd0 || mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL hold_drain got cnt=%0d vld=%b exp 0/0", outstanding_o, mem_valid_o);
    end
  endtask

  task automatic test_max_outstanding();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      req_valid_i = 3'b001; mem_ready_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 3'b001 || outstanding_o !== 4'(c)) begin
        errors++; $display("FAIL max_fill[%0d] got rdy=%b cnt=%0d exp 001/%0d", c, req_ready_o, outstanding_o, c);
      end
    end
    next_cycle(); #1;
    checks++;
    if (req_ready_o !== 3'b000 || outstanding_o !== 4'd7 || mem_valid_o !== 1'b1) begin
      errors++; $display("FAIL max_full got rdy=%b cnt=%0d vld=%b exp 000/7/1", req_ready_o, outstanding_o, mem_valid_o);
    end
    next_cycle(); #1;
    checks++;
    if (req_ready_o !== 3'b000 || outstanding_o !== 4'd7 || mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL max_stall got rdy=%b cnt=%0d vld=%b exp 000/7/0", req_ready_o, outstanding_o, mem_valid_o);
    end
    next_cycle();
    rsp_valid_i = 1'b1; rsp_src_i = 2'd0;
    #1;
    checks++;
    if (req_ready_o !== 3'b000 || rsp_valid_o !== 3'b001) begin
      errors++; $display("FAIL max_rsp got rdy=%b rsp=%b exp 000/001", req_ready_o, rsp_valid_o);
    end
    next_cycle();
    rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 3'b001 || outstanding_o !== 4'd6) begin
      errors++; $display("FAIL max_resume got rdy=%b cnt=%0d exp 001/6", req_ready_o, outstanding_o);
    end
    next_cycle();
    req_valid_i = 3'b000;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      rsp_valid_i = 1'b1; rsp_src_i = 2'd0;
    end
    next_cycle();
    rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 4'd3 || mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL max_drain got cnt=%0d vld=%b exp 3/0", outstanding_o, mem_valid_o);
    end
  endtask

  task automatic test_back_to_back_rsp();
    req_valid_i = 3'b100; rsp_valid_i = 1'b1; rsp_src_i = 2'd1; mem_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 3'b100 || rsp_valid_o !== 3'b010) begin
      errors++; $display("FAIL simul_cycle got rdy=%b rsp=%b exp 100/010", req_ready_o, rsp_valid_o);
    end
    next_cycle();
    req_valid_i = 3'b000; rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 4'd3 || mem_valid_o !== 1'b1 || mem_src_o !== 2'd2 || rsp_valid_o !== 3'b000) begin
      errors++; $display("FAIL simul_count got cnt=%0d vld=%b src=%0d rsp=%b exp 3/1/2/000",
                         outstanding_o, mem_valid_o, mem_src_o, rsp_valid_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_and_err();
    req_valid_i = 3'b001; mem_ready_i = 1'b0;
    next_cycle();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 3'b000 || mem_valid_o !== 1'b1 || outstanding_o !== 4'd4) begin
      errors++; $display("FAIL mid_reset_in got rdy=%b vld=%b cnt=%0d exp 000/1/4", req_ready_o, mem_valid_o, outstanding_o);
    end
    next_cycle();
    rst_ni = 1'b1; req_valid_i = 3'b000; mem_ready_i = 1'b1;
    #1;
    checks++;
    if (mem_valid_o !== 1'b0 || outstanding_o !== 4'd0 || err_o !== 1'b0 || mem_addr_o !== 64'd0) begin
      errors++; $display("FAIL mid_reset_out got vld=%b cnt=%0d err=%b addr=%h exp 0/0/0/0",
                         mem_valid_o, outstanding_o, err_o, mem_addr_o);
    end
    next_cycle();
    rsp_valid_i = 1'b1; rsp_src_i = 2'd0;
    #1;
    checks++;
    if (rsp_valid_o !== 3'b001 || err_o !== 1'b0) begin
      errors++; $display("FAIL late_rsp got rsp=%b err=%b exp 001/0", rsp_valid_o, err_o);
    end
    next_cycle();
    rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1 || outstanding_o !== 4'd0) begin
      errors++; $display("FAIL underflow_err got err=%b cnt=%0d exp 1/0", err_o, outstanding_o);
    end
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0 || outstanding_o !== 4'd0 || mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL err_clear got err=%b cnt=%0d vld=%b exp 0/0/0", err_o, outstanding_o, mem_valid_o);
    end
  endtask

  task automatic test_bad_src();
    next_cycle();
    req_valid_i = 3'b001; mem_ready_i = 1'b1;
    next_cycle();
    req_valid_i = 3'b000;
    #1;
    checks++;
    if (outstanding_o !== 4'd1 || err_o !== 1'b0) begin
      errors++; $display("FAIL badsrc_setup got cnt=%0d err=%b exp 1/0", outstanding_o, err_o);
    end
    next_cycle();
    rsp_valid_i = 1'b1; rsp_src_i = 2'd3;
    #1;
    checks++;
    if (rsp_valid_o !== 3'b000) begin errors++; $display("FAIL badsrc_route got %b exp 000", rsp_valid_o); end
    next_cycle();
    rsp_valid_i = 1'b0; rsp_src_i = 2'd0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL badsrc_err got %b exp 1", err_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_hold_stable();
    test_max_outstanding();
    test_back_to_back_rsp();
    test_reset_mid_and_err();
    test_bad_src();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NumReq, default 3, is the number of requesters (0=icache, 1=dcache, 2=ptw); range 2..8.
REQ-002 Parameter AddrWidth, default 64, is the request address width.
REQ-003 Parameter TidWidth, default 4, is the per-request transaction ID width.
REQ-004 Parameter MaxOutstanding, default 7, is the maximum number of accepted requests awaiting a response; range 1..15.
REQ-005 The block SHALL have one clock, clk_i; its reset, rst_ni, SHALL be synchronous and active-low.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_ni  in  1  synchronous active-low reset.
REQ-008 req_valid_i  in  NumReq  per-requester request valid.
REQ-009 req_ready_o  out  NumReq  per-requester accept, at most one bit high.
REQ-010 req_addr_i  in  NumReq*AddrWidth  packed request addresses, requester i at slice i.
REQ-011 req_tid_i  in  NumReq*TidWidth  packed request IDs.
REQ-012 mem_valid_o / mem_ready_i  out/in  1/1  downstream request handshake.
REQ-013 mem_addr_o, mem_tid_o, mem_src_o  out  AddrWidth, TidWidth, clog2(NumReq)  registered downstream payload and source index.
REQ-014 rsp_valid_i, rsp_src_i  in  1, clog2(NumReq)  downstream response and its source index.
REQ-015 rsp_valid_o  out  NumReq  response routed to requester rsp_src_i.
REQ-016 outstanding_o  out  4  current outstanding count; err_o  out  1  sticky protocol error.

Function
REQ-017 The FSM SHALL have states IDLE (output register empty), SEND (output register full, mem_valid_o=1) and STALL (output register empty, outstanding_o==MaxOutstanding).
REQ-018 An accept SHALL occur when a requester is granted, outstanding_o<MaxOutstanding, and state is IDLE or state is SEND with mem_ready_i=1 in the same cycle.
REQ-019 req_ready_o[g] SHALL be high combinationally in the accept cycle for granted requester g only; req_ready_o SHALL never be high while req_valid_i[g]=0.
REQ-020 On accept, addr, tid and index g SHALL be loaded into the output register; mem_valid_o SHALL rise the next cycle (latency 1).
REQ-021 mem_addr_o/mem_tid_o/mem_src_o SHALL hold stable while mem_valid_o=1 and mem_ready_i=0.
REQ-022 SEND with mem_ready_i=1 and no accept SHALL go to IDLE, or to STALL if outstanding_o==MaxOutstanding.
REQ-023 STALL SHALL go to IDLE on the cycle after a response decrements the count.
REQ-024 Grant SHALL be round-robin: search starts at last-accepted index +1 modulo NumReq; pointer updates only on accept.
REQ-025 outstanding_o SHALL increment on accept, decrement on rsp_valid_i, and stay unchanged when both occur in one cycle.
REQ-026 rsp_valid_o SHALL equal rsp_valid_i one-hot decoded by rsp_src_i, combinationally, zero otherwise.
REQ-027 rsp_valid_i with outstanding_o==0 SHALL set err_o and leave the count at 0; rsp_src_i>=NumReq SHALL set err_o and drive rsp_valid_o=0.
REQ-028 err_o SHALL remain high until reset.

Reset
REQ-029 With rst_ni=0 at a rising edge: state IDLE, round-robin pointer NumReq-1 (requester 0 first), outstanding_o=0, err_o=0, mem_valid_o=0, payload registers 0.
REQ-030 Reset mid-transaction SHALL discard the output register and count; responses arriving after reset SHALL set err_o.
REQ-031 req_ready_o SHALL be 0 during a cycle in which rst_ni=0.

Configuration
REQ-032 Macro MEM_REQ_ARBITER_FIXED_PRIO_EN defined: grant SHALL be fixed priority, lowest index wins, pointer unused.
REQ-033 Macro undefined: grant SHALL be round-robin per REQ-024.

Verification
REQ-034 All three valid continuously, mem_ready_i=1, responses returned immediately -> accepts in order 0,1,2,0,1,2 (fixed-priority build: 0,0,0...).
REQ-035 Req 1 valid, mem_ready_i=0 for 5 cycles -> mem_valid_o high from cycle 2, payload stable, no further accept until mem_ready_i=1.
REQ-036 7 accepts with no responses -> outstanding_o=7, state STALL, req_ready_o=0; one rsp_valid_i -> count 6, accept resumes next cycle.
REQ-037 Accept and rsp_valid_i same cycle at count 3 -> count stays 3, rsp_valid_o[rsp_src_i] pulses.
REQ-038 rsp_valid_i at count 0 -> err_o=1 and sticky; rst_ni=0 one cycle -> err_o=0, outstanding_o=0, mem_valid_o=0.
